// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the multi-port register file
package regfile_pkg;
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback-facing bus of the register file
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::RF_DATA_W,
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
  parameter int NUM_RD = regfile_pkg::RF_NUM_RD
);
  logic                     regwrite;
  logic [ADDR_W-1:0]        wr;
  logic [DATA_W-1:0]        write_data;
  logic [NUM_RD*ADDR_W-1:0] rr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     ready;
  modport master (output regwrite, wr, write_data, rr, input rdata, ready);
  modport slave (input regwrite, wr, write_data, rr, output rdata, ready);
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: post-reset clear sequencer that walks every register once, then raises ready
module regfile_clr_fsm #(
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);
  import regfile_pkg::*;
  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  // state and clear index; reset restarts the sweep from register 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // leave CLEAR on the cycle that clears the last register, so the index never wraps in use
  always_comb begin
    state_d   = (state_q == RF_CLEAR && clr_idx_q == '1) ? RF_RUN : state_q;
    clr_idx_d = (state_q == RF_CLEAR) ? clr_idx_q + ADDR_W'(1) : clr_idx_q;
  end
  // clear strobe and ready are pure functions of the current state
  always_comb begin
    clr_we_o   = state_q == RF_CLEAR;
    clr_addr_o = clr_idx_q;
    ready_o    = state_q == RF_RUN;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardware clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_mp #(
  parameter int DATA_W   = regfile_pkg::RF_DATA_W,
  parameter int ADDR_W   = regfile_pkg::RF_ADDR_W,
  parameter int NUM_RD   = regfile_pkg::RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input logic      clock,
  input logic      reset,
  regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wr_en;
  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clock      (clock),
    .reset      (reset),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );
  assign bus.ready = ready;
  // writes are dropped outside RUN and, with a hardwired zero, to register 0
  always_comb wr_en = ready && bus.regwrite && !(ZERO_REG != 0 && bus.wr == '0);
  // storage: the clear sweep owns the array until RUN
  always_ff @(posedge clock) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_en) mem_q[bus.wr] <= bus.write_data;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.rr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign bus.rdata[k*DATA_W +: DATA_W] = (!ready || (ZERO_REG != 0 && ra == '0)) ? '0 :
                                           (wr_en && bus.wr == ra) ? bus.write_data : mem_q[ra];
`else
    assign bus.rdata[k*DATA_W +: DATA_W] = (!ready || (ZERO_REG != 0 && ra == '0)) ? '0 : mem_q[ra];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sequence, write/read ports, zero register and forwarding
module tb_regfile_mp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus_b ();
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    bus_a.regwrite = 0; bus_a.wr = '0; bus_a.write_data = '0; bus_a.rr = '0;
    bus_b.regwrite = 0; bus_b.wr = '0; bus_b.write_data = '0; bus_b.rr = '0;
    tick();
    #1;
    check("rst_ready_a", 128'(bus_a.ready), 128'(0));
    check("rst_rdata_b", bus_b.rdata, 128'(0));
    reset = 1'b0;
    bus_a.regwrite = 1; bus_a.wr = 5'd5; bus_a.write_data = 32'hDEADBEEF; bus_a.rr = {5'd5, 5'd5};
    bus_b.rr = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("clr_ready_a_%0d", i), 128'(bus_a.ready), 128'(i == 32));
      check($sformatf("clr_ready_b_%0d", i), 128'(bus_b.ready), 128'(i == 32));
      if (i < 32) begin
        check($sformatf("clr_rdata_a_%0d", i), 128'(bus_a.rdata), 128'(0));
        check($sformatf("clr_rdata_b_%0d", i), bus_b.rdata, 128'(0));
      end
    end
    bus_a.regwrite = 0;
    for (int r = 0; r < 32; r++) begin
      bus_a.rr = {5'(r), 5'(31 - r)};
      #1;
      check($sformatf("zero_a_%0d", r), 128'(bus_a.rdata), 128'(0));
    end
    bus_a.regwrite = 1; bus_a.wr = 5'd0; bus_a.write_data = 32'hFFFFFFFF;
    bus_b.regwrite = 1; bus_b.wr = 5'd0; bus_b.write_data = 32'hFFFFFFFF;
    tick();
    bus_a.regwrite = 0; bus_b.regwrite = 0;
    bus_a.rr = '0; bus_b.rr = '0;
    #1;
    check("r0_hardwired_a", 128'(bus_a.rdata[31:0]), 128'(0));
    check("r0_plain_b", 128'(bus_b.rdata[31:0]), 128'(32'hFFFFFFFF));
    bus_a.regwrite = 1; bus_a.wr = 5'd7; bus_a.write_data = 32'h12345678; bus_a.rr = {5'd7, 5'd7};
    #1;
    check("wr7_same_cycle", 128'(bus_a.rdata), BYP ? 128'({2{32'h12345678}}) : 128'(0));
    tick();
    bus_a.regwrite = 0;
    #1;
    check("wr7_next_cycle", 128'(bus_a.rdata), 128'({2{32'h12345678}}));
    for (int i = 1; i <= 4; i++) begin
      bus_b.regwrite = 1; bus_b.wr = 5'(i); bus_b.write_data = 32'(i * 32'h11);
      tick();
    end
    bus_b.regwrite = 0;
    bus_b.rr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    check("four_ports_b", bus_b.rdata, {32'h44, 32'h33, 32'h22, 32'h11});
    bus_b.rr = {5'd1, 5'd1, 5'd4, 5'd0};
    #1;
    check("shared_addr_b", bus_b.rdata, {32'h11, 32'h11, 32'h44, 32'hFFFFFFFF});
    bus_a.regwrite = 1; bus_a.wr = 5'd3; bus_a.write_data = 32'hCAFEF00D; bus_a.rr = {5'd0, 5'd3};
    tick();
    bus_a.regwrite = 0;
    #1;
    check("r3_written", 128'(bus_a.rdata), 128'({32'h0, 32'hCAFEF00D}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_clear_ready", 128'(bus_a.ready), 128'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("reclr_ready_%0d", i), 128'(bus_a.ready), 128'(i == 32));
    end
    #1;
    check("r3_cleared", 128'(bus_a.rdata), 128'(0));
    bus_b.rr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    check("b_cleared", bus_b.rdata, 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
